// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared between alu_operand_loader and tt_um_8bitALU.
//   - state_t : loader FSM states (IDLE, GOT_A, GOT_B, ISSUE, WAIT_RES)
//   - OPW     : opcode width presented to the ALU
//   - FLAG_*  : bit positions inside the {C,Z,N,V} flag nibble
//   - OP_*    : opcode encodings understood by the ALU
package alu_pkg;

  localparam int OPW = 4;

  // alu_flags / flags_out are packed {C,Z,N,V}, so C is the MSB.
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam logic [OPW-1:0] OP_NOP = 4'h0;
  localparam logic [OPW-1:0] OP_ADD = 4'h1;
  localparam logic [OPW-1:0] OP_SUB = 4'h2;
  localparam logic [OPW-1:0] OP_AND = 4'h3;
  localparam logic [OPW-1:0] OP_OR  = 4'h4;
  localparam logic [OPW-1:0] OP_XOR = 4'h5;
  localparam logic [OPW-1:0] OP_SHL = 4'h6;
  localparam logic [OPW-1:0] OP_SHR = 4'h7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GOT_A    = 3'd1,
    GOT_B    = 3'd2,
    ISSUE    = 3'd3,
    WAIT_RES = 3'd4
  } state_t;

endpackage

// File: rtl/strobe_sync_edge.sv
// strobe_sync_edge: brings the asynchronous pin strobe into the clk domain
// through a SYNC_STAGES-deep flop chain (SYNC_STAGES must be at least 2) and
// emits a one-cycle pulse on its synchronised rising edge.
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset (all flops to 0)
//   i_async in   raw strobe from the pin
//   o_rise  out  single-cycle rising-edge pulse
// The chain free-runs regardless of any enable, so a consumer that ignores
// pulses for a while never sees a stale edge afterwards.
module strobe_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: byte-serial command front end for tt_um_8bitALU.
// Three strobed bytes (A, B, opcode) are collected from data_in, presented to
// the ALU as one valid/ready transaction, and the returned result and flags
// are held on the output pins.
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 enable; low freezes all state and discards strobe edges
//   load_stb, data_in   asynchronous byte strobe and byte bus
//   alu_a/b/op, alu_valid, alu_ready   operand transaction to the ALU
//   alu_res_valid, alu_result, alu_flags  single-cycle result return
//   result_out, flags_out, res_valid   held result, {C,Z,N,V}, freshness
//   busy, err           not-IDLE indicator, sticky error
//   dbg_state           current FSM state (alu_pkg::state_t encoding)
// Handshake: alu_a/alu_b/alu_op are stable whenever alu_valid is high; a
// transfer happens on a clock edge where alu_valid & alu_ready, after which
// alu_valid is low on the following cycle.
// Optional: define ALU_LOADER_PARITY_EN to require odd parity in the opcode
// byte (bit 7 over bits 6:0); a bad opcode byte sets err and is not issued.
module alu_operand_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int OPW         = alu_pkg::OPW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           load_stb,
  input  logic [7:0]     data_in,
  output logic [7:0]     alu_a,
  output logic [7:0]     alu_b,
  output logic [OPW-1:0] alu_op,
  output logic           alu_valid,
  input  logic           alu_ready,
  input  logic           alu_res_valid,
  input  logic [7:0]     alu_result,
  input  logic [3:0]     alu_flags,
  output logic [7:0]     result_out,
  output logic [3:0]     flags_out,
  output logic           res_valid,
  output logic           busy,
  output logic           err,
  output logic [2:0]     dbg_state
);
  import alu_pkg::*;

  localparam int              CNTW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT_CYC);

  state_t          r_state, w_state;
  logic [7:0]      r_a, w_a;
  logic [7:0]      r_b, w_b;
  logic [OPW-1:0]  r_op, w_op;
  logic [7:0]      r_result, w_result;
  logic [3:0]      r_flags, w_flags;
  logic            r_res_valid, w_res_valid;
  logic            r_err, w_err;
  logic [CNTW-1:0] r_cnt, w_cnt;
  logic [CNTW-1:0] w_cnt_inc;
  logic            w_rise;

  strobe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (load_stb),
    .o_rise  (w_rise)
  );

`ifndef ALU_LOADER_PARITY_EN
  // Opcode byte bits above OPW carry nothing in this build.
  logic w_unused_opc_hi;
  assign w_unused_opc_hi = &{1'b0, data_in[7:OPW]};
`endif

  // Saturating increment: the counter never wraps back to zero.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNTW'(1);

  always_comb begin
    w_state     = r_state;
    w_a         = r_a;
    w_b         = r_b;
    w_op        = r_op;
    w_result    = r_result;
    w_flags     = r_flags;
    w_res_valid = r_res_valid;
    w_err       = r_err;
    w_cnt       = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_a         = data_in;
          w_res_valid = 1'b0;
          w_err       = 1'b0;
          w_state     = GOT_A;
        end
      end
      GOT_A: begin
        if (w_rise) begin
          w_b     = data_in;
          w_state = GOT_B;
        end
      end
      GOT_B: begin
        if (w_rise) begin
          w_op    = data_in[OPW-1:0];
          w_state = ISSUE;
`ifdef ALU_LOADER_PARITY_EN
          // Valid byte has an odd number of ones across all 8 bits.
          if (^data_in == 1'b0) begin
            w_err   = 1'b1;
            w_state = IDLE;
          end
`endif
        end
      end
      ISSUE: begin
        if (alu_ready) begin
          w_cnt   = '0;
          w_state = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // A result arriving on the expiry cycle takes priority over the timeout.
        if (alu_res_valid) begin
          w_result    = alu_result;
          w_flags     = alu_flags;
          w_res_valid = 1'b1;
          w_state     = IDLE;
        end else begin
          w_cnt = w_cnt_inc;
          if (w_cnt_inc == CNT_MAX) begin
            w_err   = 1'b1;
            w_state = IDLE;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_flags     <= '0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else if (ena) begin
      r_state     <= w_state;
      r_a         <= w_a;
      r_b         <= w_b;
      r_op        <= w_op;
      r_result    <= w_result;
      r_flags     <= w_flags;
      r_res_valid <= w_res_valid;
      r_err       <= w_err;
      r_cnt       <= w_cnt;
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign alu_valid  = (r_state == ISSUE);
  assign result_out = r_result;
  assign flags_out  = r_flags;
  assign res_valid  = r_res_valid;
  assign busy       = (r_state != IDLE);
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
`timescale 1ns/1ps
module tb_alu_operand_loader;

  localparam int T = 16;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       load_stb = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       alu_ready = 1'b0;
  logic       alu_res_valid = 1'b0;
  logic [7:0] alu_result = 8'h00;
  logic [3:0] alu_flags = 4'h0;
  logic [7:0] alu_a, alu_b, result_out;
  logic [3:0] alu_op, flags_out;
  logic       alu_valid, res_valid, busy, err;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  alu_operand_loader #(.SYNC_STAGES(2), .TIMEOUT_CYC(T), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load_stb(load_stb), .data_in(data_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid(alu_valid),
    .alu_ready(alu_ready), .alu_res_valid(alu_res_valid), .alu_result(alu_result),
    .alu_flags(alu_flags), .result_out(result_out), .flags_out(flags_out),
    .res_valid(res_valid), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int vcnt     = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Byte edges are seen three clock edges after the pin is first sampled high;
  // the model keeps the last three pin samples and looks for a 0->1 step.
  logic [2:0]  m_hist;
  int          m_n;      // bytes collected toward the next command
  int          m_phase;  // 0 collecting, 1 offering to ALU, 2 awaiting result
  int          m_w;      // cycles spent awaiting the result
  logic [7:0]  m_a, m_b, m_res;
  logic [3:0]  m_op, m_flags;
  logic        m_rv, m_err;
  logic [11:0] exp_q[$];
  wire         m_edge = m_hist[1] & ~m_hist[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hist <= 3'b000; m_n <= 0; m_phase <= 0; m_w <= 0;
      m_a <= 8'h00; m_b <= 8'h00; m_res <= 8'h00; m_op <= 4'h0; m_flags <= 4'h0;
      m_rv <= 1'b0; m_err <= 1'b0;
    end else begin
      m_hist <= {m_hist[1:0], load_stb};
      if (ena) begin
        if (m_phase == 0) begin
          if (m_edge) begin
            if (m_n == 0) begin
              m_a <= data_in; m_rv <= 1'b0; m_err <= 1'b0; m_n <= 1;
            end else if (m_n == 1) begin
              m_b <= data_in; m_n <= 2;
            end else begin
              m_op <= data_in[3:0]; m_n <= 0;
`ifdef ALU_LOADER_PARITY_EN
              if (^data_in == 1'b0) m_err <= 1'b1;
              else m_phase <= 1;
`else
              m_phase <= 1;
`endif
            end
          end
        end else if (m_phase == 1) begin
          if (alu_ready) begin m_phase <= 2; m_w <= 0; end
        end else begin
          if (alu_res_valid) begin
            m_res <= alu_result; m_flags <= alu_flags; m_rv <= 1'b1; m_phase <= 0;
            exp_q.push_back({alu_flags, alu_result});
          end else begin
            m_w <= m_w + 1;
            if (m_w + 1 == T) begin m_err <= 1'b1; m_phase <= 0; end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare + result scoreboard ----------------
  logic prev_rv = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("alu_a",      16'(alu_a),      16'(m_a));
      chk("alu_b",      16'(alu_b),      16'(m_b));
      chk("alu_op",     16'(alu_op),     16'(m_op));
      chk("alu_valid",  16'(alu_valid),  16'(m_phase == 1));
      chk("result_out", 16'(result_out), 16'(m_res));
      chk("flags_out",  16'(flags_out),  16'(m_flags));
      chk("res_valid",  16'(res_valid),  16'(m_rv));
      chk("err",        16'(err),        16'(m_err));
      chk("busy",       16'(busy),       16'((m_phase != 0) || (m_n != 0)));
      if (alu_valid) vcnt++;
      if (res_valid && !prev_rv) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_unexpected: result 0x%0h flags 0x%0h with nothing expected", result_out, flags_out);
        end else begin
          chk("sb_result", 16'({flags_out, result_out}), 16'(exp_q.pop_front()));
        end
      end
      prev_rv <= res_valid;
    end else begin
      prev_rv <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Holds the byte across the synchroniser window; after the last byte the
  // strobe is dropped without extra idle cycles so the FSM sits in ISSUE.
  task automatic send_byte(input logic [7:0] b, input bit last);
    data_in  = b;
    load_stb = 1'b1;
    repeat (3) tick();
    load_stb = 1'b0;
    if (!last) repeat (2) tick();
  endtask

  task automatic load_bytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a, 1'b0);
    send_byte(b, 1'b0);
    send_byte(op, 1'b1);
  endtask

  // rdly: edges with alu_ready low before it is raised.
  // res_dly: cycles after the transfer before alu_res_valid; negative = never.
  task automatic handshake(input int rdly, input int res_dly, input logic [7:0] res,
                           input logic [3:0] flg, input bit extra);
    repeat (rdly) tick();
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    if (res_dly < 0) begin
      repeat (T + 2) tick();
    end else begin
      if (extra && res_dly >= 8) begin
        data_in  = 8'($urandom);
        load_stb = 1'b1;
        repeat (3) tick();
        load_stb = 1'b0;
        repeat (res_dly - 3) tick();
      end else begin
        repeat (res_dly) tick();
      end
      alu_res_valid = 1'b1;
      alu_result    = res;
      alu_flags     = flg;
      tick();
      alu_res_valid = 1'b0;
      alu_result    = 8'($urandom);
      alu_flags     = 4'($urandom);
      repeat (2) tick();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int v0;
    repeat (3) tick();
    chk("rst_alu_a",     16'(alu_a),      16'h0000);
    chk("rst_result",    16'(result_out), 16'h0000);
    chk("rst_res_valid", 16'(res_valid),  16'h0000);
    chk("rst_err",       16'(err),        16'h0000);
    chk("rst_busy",      16'(busy),       16'h0000);
    chk("rst_valid",     16'(alu_valid),  16'h0000);
    chk("rst_state",     16'(dbg_state),  16'(alu_pkg::IDLE));
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (2) tick();

    // Normal load
    v0 = vcnt;
    load_bytes(8'h12, 8'h34, 8'h01);
    handshake(0, 2, 8'h46, 4'h0, 1'b0);
    chk("n_alu_a",     16'(alu_a),      16'h0012);
    chk("n_alu_b",     16'(alu_b),      16'h0034);
    chk("n_alu_op",    16'(alu_op),     16'h0001);
    chk("n_vcycles",   16'(vcnt - v0),  16'd1);
    chk("n_result",    16'(result_out), 16'h0046);
    chk("n_res_valid", 16'(res_valid),  16'h0001);
    chk("n_busy",      16'(busy),       16'h0000);

    // Backpressure: five edges with ready low
    v0 = vcnt;
    load_bytes(8'hA5, 8'h5A, 8'h02);
    handshake(5, 3, 8'h77, 4'h9, 1'b0);
    chk("bp_vcycles", 16'(vcnt - v0),  16'd6);
    chk("bp_result",  16'(result_out), 16'h0077);
    chk("bp_flags",   16'(flags_out),  16'h0009);

    // Timeout: err after exactly T cycles in WAIT_RES
    load_bytes(8'h01, 8'h02, 8'h04);
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    repeat (T - 1) tick();
    chk("to_err_early",  16'(err),  16'h0000);
    chk("to_busy_early", 16'(busy), 16'h0001);
    tick();
    chk("to_err",        16'(err),        16'h0001);
    chk("to_busy",       16'(busy),       16'h0000);
    chk("to_result",     16'(result_out), 16'h0077);
    repeat (3) tick();
    send_byte(8'h55, 1'b0);
    chk("to_err_clr",    16'(err),       16'h0000);
    chk("to_rv_clr",     16'(res_valid), 16'h0000);
    send_byte(8'h66, 1'b0);
    send_byte(8'h10, 1'b1);
    handshake(1, 4, 8'hBB, 4'h1, 1'b0);

    // Result on the expiry cycle wins
    load_bytes(8'h21, 8'h43, 8'h08);
    handshake(0, T - 1, 8'h3C, 4'h4, 1'b0);
    chk("sim_err",    16'(err),        16'h0000);
    chk("sim_rv",     16'(res_valid),  16'h0001);
    chk("sim_result", 16'(result_out), 16'h003C);

    // Asynchronous reset after A and B
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_alu_a",  16'(alu_a),      16'h0000);
    chk("ar_alu_b",  16'(alu_b),      16'h0000);
    chk("ar_busy",   16'(busy),       16'h0000);
    chk("ar_result", 16'(result_out), 16'h0000);
    chk("ar_rv",     16'(res_valid),  16'h0000);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    load_bytes(8'hE1, 8'hE2, 8'h01);
    handshake(2, 1, 8'hC3, 4'hA, 1'b0);
    chk("ar2_alu_a",  16'(alu_a),      16'h00E1);
    chk("ar2_alu_b",  16'(alu_b),      16'h00E2);
    chk("ar2_result", 16'(result_out), 16'h00C3);

    // Edge while disabled is discarded
    send_byte(8'h10, 1'b0);
    ena = 1'b0;
    send_byte(8'hEE, 1'b0);
    ena = 1'b1;
    send_byte(8'h20, 1'b0);
    send_byte(8'h02, 1'b1);
    handshake(1, 4, 8'h99, 4'h2, 1'b0);
    chk("en_alu_a",  16'(alu_a),      16'h0010);
    chk("en_alu_b",  16'(alu_b),      16'h0020);
    chk("en_result", 16'(result_out), 16'h0099);

`ifdef ALU_LOADER_PARITY_EN
    v0 = vcnt;
    load_bytes(8'h11, 8'h22, 8'h03);
    handshake(0, 2, 8'h55, 4'h0, 1'b0);
    chk("par_bad_err",   16'(err),       16'h0001);
    chk("par_bad_valid", 16'(vcnt - v0), 16'd0);
    load_bytes(8'h11, 8'h22, 8'h83);
    handshake(0, 2, 8'h56, 4'h0, 1'b0);
    chk("par_ok_op",  16'(alu_op), 16'h0003);
    chk("par_ok_err", 16'(err),    16'h0000);
`endif

    // Randomised transactions against the model
    for (int i = 0; i < 40; i++) begin
      int rd;
      int rs;
      rd = int'($urandom_range(4, 0));
      rs = ($urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(20, 0));
      load_bytes(8'($urandom), 8'($urandom), 8'($urandom));
      handshake(rd, rs, 8'($urandom), 4'($urandom), 1'($urandom));
    end

    repeat (4) tick();
    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Upstream command stage for tt_um_8bitALU. Pins are scarce, so operands and opcode arrive byte-serially on an 8-bit bus, qualified by an external load strobe.
- The block synchronises the strobe and sequences three bytes (A, B, opcode).
- It issues one valid/ready transaction to the ALU, then captures and holds the ALU result and flags for the output pins.
- It owns all operand/result staging; the ALU stays purely computational.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the load_stb synchroniser (min 2).
- TIMEOUT_CYC, 16, cycles allowed in WAIT_RES before aborting with err.
- OPW, 4, opcode width presented to the ALU.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; when low, FSM holds state and ignores strobes
- load_stb  in  1  asynchronous byte strobe from pin; byte is taken on its synchronised rising edge
- data_in  in  8  byte bus (ui_in)
- alu_a  out  8  operand A to ALU
- alu_b  out  8  operand B to ALU
- alu_op  out  OPW  opcode to ALU
- alu_valid  out  1  operands/opcode valid
- alu_ready  in  1  ALU accepts; transfer when alu_valid & alu_ready
- alu_res_valid  in  1  ALU result strobe (single cycle)
- alu_result  in  8  ALU result
- alu_flags  in  4  {C,Z,N,V}
- result_out  out  8  held result (uo_out)
- flags_out  out  4  held flags
- res_valid  out  1  result_out is fresh; set on capture, cleared by the next A byte
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky; set on timeout (or parity fail with feature); cleared by the next A byte

Behaviour:
- Reset: all outputs and registers 0, FSM = IDLE, synchroniser flops 0.
- Strobe edge: data_in is sampled in the same cycle the edge is detected. Latency from pin edge is SYNC_STAGES+1 cycles. data_in must be stable across that window (system constraint, not checked).
- FSM:
  - IDLE: edge -> latch alu_a; clear res_valid and err -> GOT_A.
  - GOT_A: edge -> latch alu_b -> GOT_B.
  - GOT_B: edge -> latch alu_op = data_in[OPW-1:0] -> ISSUE.
  - ISSUE: alu_valid=1. On alu_ready -> WAIT_RES, and alu_valid drops the next cycle. alu_a/b/op are stable while alu_valid is high.
  - WAIT_RES: on alu_res_valid -> capture result_out and flags_out, set res_valid -> IDLE. If the counter reaches TIMEOUT_CYC first -> set err, leave result_out unchanged -> IDLE.
- Strobe edges in ISSUE/WAIT_RES are ignored; no queuing.
- alu_res_valid outside WAIT_RES is ignored.
- alu_res_valid on the same cycle the timeout counter expires: the result wins; capture it, no err.
- Timeout counter is $clog2(TIMEOUT_CYC+1) bits, zeroed on entering WAIT_RES, saturates; no wrap.
- ena low: all state, counters and outputs freeze. An edge detected while ena is low is discarded. The synchroniser keeps running, so no false edge appears when ena returns.
- rst_n asserted mid-transaction (any state): immediate return to reset values. A partially loaded A/B is discarded.

Optional Feature:
- Macro ALU_LOADER_PARITY_EN.
- Defined: the opcode byte's bit 7 is odd parity over bits [6:0]. On mismatch in GOT_B: set err, do not issue, -> IDLE. alu_op is still latched.
- Undefined: bits [7:OPW] of the opcode byte are ignored and no check occurs.

Decomposition:
- Shared package alu_pkg holds:
  - FSM state enum (IDLE, GOT_A, GOT_B, ISSUE, WAIT_RES)
  - OPW
  - flag bit index constants FLAG_C/Z/N/V
  - opcode localparams (shared with tt_um_8bitALU)
- One sub-module: strobe_sync_edge (SYNC_STAGES flop chain plus rising-edge detect, async reset to 0). Everything else lives in the top.

Test Plan:
- Normal load: strobe bytes 0x12, 0x34, 0x01; ALU ready immediately; alu_res_valid with 0x46 and flags 0x0 two cycles later -> alu_a=0x12, alu_b=0x34, alu_op=1; alu_valid high exactly one cycle; result_out=0x46, res_valid=1, busy=0.
- Backpressure: alu_ready held low 5 cycles after GOT_B -> alu_valid and operands stable all 5 cycles, single transfer, then normal completion.
- Timeout: alu_res_valid never asserted -> err=1 after exactly TIMEOUT_CYC cycles in WAIT_RES; FSM IDLE; result_out keeps its prior value. The next A byte clears err.
- Simultaneous: alu_res_valid asserted on the expiry cycle -> result captured, err=0.
- Async reset mid-load after the A and B bytes -> all outputs 0 immediately. A fresh 3-byte sequence then completes correctly.
- Parity (with ALU_LOADER_PARITY_EN): opcode byte 0x03 (bad parity) -> err=1, alu_valid never asserted. Opcode byte 0x83 -> issues with alu_op=3.
